// File: rtl/fetch_unit_if.sv
// Fetch unit bus interface.
// Bundles the instruction-memory request/response channel, the redirect input and the
// decode-side handshake. Signal names follow the fetch unit's external port list.
//   master : fetch unit view (drives requests and decode outputs)
//   slave  : environment view (memory, redirect source, decode stage)
// Optional macro FETCH_MISALIGN_TRAP_EN adds the fetch_misalign fault output.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output fetch_misalign,
`endif
    output imem_req_valid,
    output imem_req_addr,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready
  );

  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  fetch_misalign,
`endif
    input  imem_req_valid,
    input  imem_req_addr,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues word-aligned fetch requests from a PC register, tracks in-flight requests in an
// address queue, buffers returned instructions in a DEPTH-entry FIFO and presents them to
// decode. Redirects flush the FIFO and discard responses of requests already in flight.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - fetch_unit_if.master (imem request/response, redirect, decode handshake)
// Parameters: RESET_PC (PC after reset), DEPTH (in-flight + buffered limit, power of two 2..8).
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects enter a FAULT state that stops
// fetching and raises fetch_misalign until an aligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            started_q, started_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [PtrW-1:0] fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;

  logic [31:0] aq_pc    [DEPTH];
  logic [31:0] fq_instr [DEPTH];
  logic [31:0] fq_pc    [DEPTH];

  logic          req_valid, req_fire, id_valid, pop, rsp, push, flush, credit, fault_redirect;
  logic [CntW:0] occ;
  logic [31:0]   redirect_tgt;

  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
  assign flush        = bus.redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fault_redirect = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_misalign = !reset && (state_q == StFault);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign fault_redirect      = 1'b0;
`endif

  always_comb begin
    id_valid = !reset && (fifo_cnt_q != '0);
    pop      = id_valid && bus.id_ready;
    // A pop this cycle frees a slot before the new request's response can land, so it counts
    // toward credit; this keeps back-to-back fetch at full rate without overflowing.
    occ      = {1'b0, inflight_q} + {1'b0, fifo_cnt_q} - (CntW+1)'(pop);
    credit   = occ < (CntW+1)'(DEPTH);
    req_valid = !reset && started_q && (state_q == StRun) && !bus.redirect_valid && credit;
    req_fire  = req_valid && bus.imem_req_ready;
    rsp       = bus.imem_rsp_valid && (inflight_q != '0);
    // Stale responses (drop pending) and one coinciding with a redirect never reach the FIFO.
    push      = rsp && (drop_q == '0) && !flush;
  end

  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = pc_q;
    bus.id_valid       = id_valid;
    bus.id_instr       = fq_instr[fq_rd_q];
    bus.id_pc          = fq_pc[fq_rd_q];
    bus.id_pc_plus4    = fq_pc[fq_rd_q] + 32'd4;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    started_d  = 1'b1;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q;
    aq_wr_d    = aq_wr_q;
    aq_rd_d    = aq_rd_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;

    if (flush) begin
      pc_d = redirect_tgt;
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    if (req_fire && !rsp) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!req_fire && rsp) begin
      inflight_d = inflight_q - CntW'(1);
    end

    // Everything still in flight after a redirect belongs to the old stream.
    if (flush) begin
      drop_d = inflight_q - CntW'(rsp);
    end else if (rsp && (drop_q != '0)) begin
      drop_d = drop_q - CntW'(1);
    end

    if (req_fire) aq_wr_d = aq_wr_q + PtrW'(1);
    if (rsp)      aq_rd_d = aq_rd_q + PtrW'(1);

    if (flush) begin
      fifo_cnt_d = '0;
      fq_wr_d    = '0;
      fq_rd_d    = '0;
    end else begin
      if (push) fq_wr_d = fq_wr_q + PtrW'(1);
      if (pop)  fq_rd_d = fq_rd_q + PtrW'(1);
      if (push && !pop) begin
        fifo_cnt_d = fifo_cnt_q + CntW'(1);
      end else if (!push && pop) begin
        fifo_cnt_d = fifo_cnt_q - CntW'(1);
      end
    end

    if (flush) begin
      state_d = fault_redirect ? StFault : StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      inflight_q <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      started_q  <= started_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
    end
  end

  // Storage arrays carry no reset; occupancy counters define validity.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      aq_pc[aq_wr_q] <= pc_q;
    end
    if (push) begin
      fq_instr[fq_wr_q] <= bus.imem_rsp_data;
      fq_pc[fq_wr_q]    <= aq_pc[aq_rd_q];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] ResetPc = 32'h0000_1000;
  localparam int unsigned Depth   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(ResetPc),
    .DEPTH   (Depth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory model: in-order responses, random latency >= 1, random request acceptance.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          ready_pct = 100;
  int          n_req_fire;

  // Reference: the stream decode should see and the stream memory should be asked for.
  logic [31:0] exp_req, exp_id;
  bit          fault, redir_last;

  logic        s_req_valid, s_req_fire, s_id_valid, s_pop, s_rsp, s_misalign;
  logic [31:0] s_req_addr, s_id_pc, s_id_instr, s_pc4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // One clock cycle: present memory response, sample outputs mid-cycle, update reference.
  task automatic step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (!reset && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    #3;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_id_valid  = bus.id_valid;
    s_id_pc     = bus.id_pc;
    s_id_instr  = bus.id_instr;
    s_pc4       = bus.id_pc_plus4;
    s_rsp       = bus.imem_rsp_valid;
    s_req_fire  = s_req_valid && bus.imem_req_ready;
    s_pop       = s_id_valid && bus.id_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_misalign  = bus.fetch_misalign;
`else
    s_misalign  = 1'b0;
`endif
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      exp_req    = ResetPc;
      exp_id     = ResetPc;
      fault      = 1'b0;
      redir_last = 1'b0;
    end else begin
      if (redir_last) begin
        n_checks++;
        if (s_id_valid !== 1'b0)
          $display("FAIL id_valid_after_redirect: got %b want 0 (cyc %0d)", s_id_valid, cyc);
          if (s_id_valid !== 1'b0) n_fail++;
      end
      if (s_req_valid) begin
        n_checks++;
        if (s_req_addr !== exp_req || bus.redirect_valid || fault) begin
          n_fail++;
          $display("FAIL req_addr: got %h want %h (redirect %b fault %b cyc %0d)",
                   s_req_addr, exp_req, bus.redirect_valid, fault, cyc);
        end
      end
      if (s_id_valid) begin
        n_checks++;
        if (s_id_pc !== exp_id || s_id_instr !== instr_of(exp_id) || s_pc4 !== exp_id + 32'd4) begin
          n_fail++;
          $display("FAIL id_out: got pc %h instr %h pc4 %h want pc %h instr %h pc4 %h (cyc %0d)",
                   s_id_pc, s_id_instr, s_pc4, exp_id, instr_of(exp_id), exp_id + 32'd4, cyc);
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      n_checks++;
      if (s_misalign !== fault) begin
        n_fail++;
        $display("FAIL fetch_misalign: got %b want %b (cyc %0d)", s_misalign, fault, cyc);
      end
`endif
      if (s_req_fire) begin
        mq_addr.push_back(s_req_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        n_req_fire++;
        exp_req = exp_req + 32'd4;
      end
      if (s_pop) exp_id = exp_id + 32'd4;
      redir_last = bus.redirect_valid;
      if (bus.redirect_valid) begin
        exp_req = {bus.redirect_pc[31:2], 2'b00};
        exp_id  = {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        fault = (bus.redirect_pc[1:0] != 2'b00);
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_req_fire = 0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
  endtask

  // Step until decode sees an instruction; expiry is a failure.
  task automatic wait_id(input string name);
    int k = 0;
    while (!s_id_valid && k < 30) begin
      step();
      k++;
    end
    if (!s_id_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got id_valid 0 want 1", name);
    end
  endtask

  task automatic test_reset();
    bus.id_ready = 1'b1;
    ready_pct    = 100;
    reset        = 1'b1;
    step();
    n_checks++;
    if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0 || s_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req %b id %b mis %b want 0 0 0",
               s_req_valid, s_id_valid, s_misalign);
    end
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0 || s_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got req %b id %b mis %b want 0 0 0",
               s_req_valid, s_id_valid, s_misalign);
    end
    step();
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== ResetPc) begin
      n_fail++;
      $display("FAIL first_req: got valid %b addr %h want 1 %h", s_req_valid, s_req_addr, ResetPc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    s_id_valid = 1'b0;
    wait_id("stream");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (s_id_valid !== 1'b1 || s_id_pc !== ResetPc + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL stream_pc%0d: got valid %b pc %h want 1 %h",
                 i, s_id_valid, s_id_pc, ResetPc + 32'(4 * i));
      end
      step();
    end
  endtask

  task automatic test_stall();
    int pops = 0;
    do_reset();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_id_valid) begin
        n_checks++;
        if (s_id_instr !== instr_of(ResetPc) || s_id_pc !== ResetPc) begin
          n_fail++;
          $display("FAIL stall_hold: got instr %h pc %h want %h %h",
                   s_id_instr, s_id_pc, instr_of(ResetPc), ResetPc);
        end
      end
    end
    n_checks++;
    if (n_req_fire != int'(Depth) || s_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_requests: got %0d reqs valid %b want %0d reqs valid 0",
               n_req_fire, s_req_valid, Depth);
    end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_pop && pops < 2) begin
        n_checks++;
        if (s_id_pc !== ResetPc + 32'(4 * pops)) begin
          n_fail++;
          $display("FAIL stall_drain%0d: got %h want %h", pops, s_id_pc, ResetPc + 32'(4 * pops));
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 2) begin
      n_fail++;
      $display("FAIL stall_drain_count: got %0d want 2", pops);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (mq_addr.size() != 2) begin
      n_fail++;
      $display("FAIL redirect_setup_outstanding: got %0d want 2", mq_addr.size());
    end
    redirect_to(32'h0000_2000);
    s_id_valid = 1'b0;
    wait_id("redirect");
    n_checks++;
    if (s_id_pc !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL redirect_first_pc: got %h want 00002000", s_id_pc);
    end
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic test_redirect_rsp_pop();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    redirect_to(32'h0000_4000);
    n_checks++;
    if (!(s_rsp && s_pop)) begin
      n_fail++;
      $display("FAIL coincide_setup: got rsp %b pop %b want 1 1", s_rsp, s_pop);
    end
    step();
    n_checks++;
    if (s_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coincide_id_valid: got %b want 0", s_id_valid);
    end
    wait_id("coincide");
    n_checks++;
    if (s_id_pc !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL coincide_first_pc: got %h want 00004000", s_id_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] fired[$];
    for (int i = 0; i < 3; i++) step();
    redirect_to(32'hFFFF_FFFC);
    s_id_valid = 1'b0;
    for (int k = 0; k < 30 && !s_id_valid; k++) begin
      step();
      if (s_req_fire) fired.push_back(s_req_addr);
    end
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_pc !== 32'hFFFF_FFFC || s_pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_top: got valid %b pc %h pc4 %h want 1 fffffffc 00000000",
               s_id_valid, s_id_pc, s_pc4);
    end
    step();
    if (s_req_fire) fired.push_back(s_req_addr);
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next_pc: got valid %b pc %h want 1 00000000", s_id_valid, s_id_pc);
    end
    n_checks++;
    if (fired.size() < 2 || fired[0] !== 32'hFFFF_FFFC || fired[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req_addr: got %0d reqs first %h second %h want fffffffc 00000000",
               fired.size(), (fired.size() > 0) ? fired[0] : 32'hx,
               (fired.size() > 1) ? fired[1] : 32'hx);
    end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    redirect_to(32'h0000_2002);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (s_misalign !== 1'b1 || s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_fault: got mis %b req %b id %b want 1 0 0",
                 s_misalign, s_req_valid, s_id_valid);
      end
    end
    redirect_to(32'h0000_3000);
    step();
    n_checks++;
    if (s_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got %b want 0", s_misalign);
    end
    wait_id("misalign");
    n_checks++;
    if (s_id_pc !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL misalign_resume_pc: got %h want 00003000", s_id_pc);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    ready_pct = 70;
    lat_min   = 1;
    lat_max   = 4;
    for (int i = 0; i < 600; i++) begin
      bus.id_ready = ($urandom_range(99) < 75);
      if ($urandom_range(19) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom();
        if ($urandom_range(3) != 0) bus.redirect_pc[1:0] = 2'b00;
      end
      step();
    end
    // Return to a clean aligned stream so the stream ends in RUN.
    bus.id_ready = 1'b1;
    redirect_to(32'h0000_8000);
    wait_id("random_tail");
    ready_pct = 100;
    lat_min   = 1;
    lat_max   = 1;
  endtask

  initial begin
    reset              = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    n_req_fire         = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp_pop();
    test_wrap();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
